dmem_serial_ctrl: RTL and testbench
===================================

DMEM_SERIAL_CTRL -- requirements
Module: dmem_serial_ctrl

Interface
REQ-001 The block SHALL run on one clock, clk; reset rst is asynchronous and active-low (asserted when 0).
REQ-002 clk  in  1  rising-edge system clock, shared with the CPU.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 addr  in  64  byte address from the CPU address bus; only addr[11:0] is used.
REQ-005 wdata  in  64  store data from the CPU data-out bus.
REQ-006 ctrl  in  11  {storetype[3:0], loadtype[3:0], MemWriteEn, MemReadEn, RegWriteEn}; RegWriteEn is ignored.
REQ-007 rdata  out  64  extended load result, driven to the CPU data-in bus.
REQ-008 stall  out  1  high while an access is in progress; the CPU holds its state while high.
REQ-009 misalign  out  1  one-cycle misaligned-access flag (see Configuration).

Function
REQ-010 Memory SHALL be MEMORY_SIZE bytes, byte-addressed, and accessed one byte per clock.
REQ-011 The FSM SHALL have three states, IDLE, ACCESS and DONE, with these transitions:
- IDLE -> ACCESS when MemReadEn or MemWriteEn is high.
- ACCESS -> DONE after the last byte.
- DONE -> IDLE unconditionally.
REQ-012 In IDLE, a request SHALL latch addr[11:0], wdata, direction and size N, and SHALL drive stall high combinationally in that same cycle.
REQ-013 Size N SHALL be decoded from the shared type codes:
- BYTE = 1, HALFWORD = 2, WORD = 4, DOUBLEWORD = 8.
- The UNSIGNED load variants use the same sizes.
REQ-014 In ACCESS, byte k (k = 0..N-1) SHALL use address (addr + k) mod MEMORY_SIZE, so accesses wrap at the top of memory.
REQ-015 Write byte order SHALL be little-endian: mem[addr+k] <= wdata[8k+7:8k].
REQ-016 Read bytes SHALL be assembled into rbuf[8k+7:8k].
REQ-017 stall SHALL be high in IDLE-with-request and in ACCESS, and low in DONE and in idle IDLE.
- An N-byte access holds stall high for N+1 cycles.
REQ-018 On entering DONE, rdata SHALL register the load result:
- sign-extended for LOAD_BYTE, LOAD_HALFWORD and LOAD_WORD;
- zero-extended for LOAD_BYTE_UNSIGNED and LOAD_HALFWORD_UNSIGNED;
- unmodified for LOAD_DOUBLEWORD.
REQ-019 rdata SHALL hold its value until the next completed load; stores SHALL leave rdata unchanged.
REQ-020 The request present during DONE SHALL NOT start a new access, because the CPU advances at the edge that leaves DONE.
REQ-021 If MemReadEn and MemWriteEn are both high, the block SHALL perform the write only.
REQ-022 An unrecognised load or store type SHALL go IDLE -> DONE without any memory access; a load then sets rdata = 0.
REQ-023 Memory SHALL be written only during ACCESS of a store.

Reset
REQ-024 While rst is low, the block SHALL hold state IDLE, stall = 0, misalign = 0, rdata = 0, and byte index = 0.
REQ-025 Reset asserted mid-access SHALL abort the access immediately.
- Bytes already written remain; no further bytes are written.
REQ-026 Memory contents SHALL NOT be cleared by reset; they are zero at simulation start.

Configuration
REQ-027 The macro DMEM_MISALIGN_TRAP_EN SHALL select misaligned-access handling.
REQ-028 With DMEM_MISALIGN_TRAP_EN defined, an access with addr mod N != 0 SHALL:
- go IDLE -> DONE with no memory access;
- assert misalign for the DONE cycle only;
- set rdata = 0 if it is a load.
REQ-029 With DMEM_MISALIGN_TRAP_EN undefined, misaligned accesses SHALL proceed byte-wise per REQ-014, and misalign SHALL be tied to 0.

Structure
REQ-030 MEMORY_SIZE, BIT_WIDTH and the LOAD_*/STORE_* codes SHALL come from the shared defs header.
- The FSM state encoding SHALL be local to the block.
REQ-031 Storage SHALL be one sub-module, dmem_byte_ram: 8-bit wide, MEMORY_SIZE deep, with synchronous write and asynchronous read.

Verification
REQ-032 Store doubleword: sd, addr 0x100, wdata 0x1122334455667788 -> stall high 9 cycles, mem[0x100..0x107] = 88,77,66,55,44,33,22,11, rdata unchanged.
REQ-033 Byte loads and extension:
- lb at 0x107 -> rdata 0x0000000000000011;
- sb 0x80 to 0x200, then lb -> 0xFFFFFFFFFFFFFF80;
- lbu at 0x200 -> 0x0000000000000080.
REQ-034 Wrap-around (MEMORY_SIZE 4096): lw at 0xFFE -> bytes read from 0xFFE, 0xFFF, 0x000, 0x001 in order, stall high 5 cycles.
REQ-035 Reset mid-access: rst low during byte 2 of an sd to 0x300 -> stall 0 immediately, state IDLE, mem[0x300..0x301] written, mem[0x302..0x307] unchanged.
REQ-036 Misaligned halfword: sh to 0x101 ->
- macro defined: misalign = 1 for one cycle, memory unchanged;
- macro undefined: mem[0x101..0x102] written, misalign = 0.
REQ-037 Simultaneous read/write: MemReadEn = MemWriteEn = 1, sw 0xDEADBEEF at 0x40 -> write performed, rdata unchanged.

Source files
------------

// File: rtl/dmem_serial_ctrl_pkg.sv
// Shared definitions for the serial data-memory controller: memory geometry,
// bus width, control-word layout and the LOAD_*/STORE_* type codes, plus
// helpers that decode access size and extend load results.
package dmem_serial_ctrl_pkg;

  localparam int unsigned MEMORY_SIZE = 4096;
  localparam int unsigned BIT_WIDTH   = 64;
  localparam int unsigned ADDR_W      = $clog2(MEMORY_SIZE);
  localparam int unsigned CTRL_W      = 11;

  // loadtype codes (ctrl[6:3])
  localparam logic [3:0] LOAD_BYTE              = 4'd1;
  localparam logic [3:0] LOAD_HALFWORD          = 4'd2;
  localparam logic [3:0] LOAD_WORD              = 4'd3;
  localparam logic [3:0] LOAD_DOUBLEWORD        = 4'd4;
  localparam logic [3:0] LOAD_BYTE_UNSIGNED     = 4'd5;
  localparam logic [3:0] LOAD_HALFWORD_UNSIGNED = 4'd6;

  // storetype codes (ctrl[10:7])
  localparam logic [3:0] STORE_BYTE       = 4'd1;
  localparam logic [3:0] STORE_HALFWORD   = 4'd2;
  localparam logic [3:0] STORE_WORD       = 4'd3;
  localparam logic [3:0] STORE_DOUBLEWORD = 4'd4;

  // Byte count of a load; 0 marks an unrecognised code.
  function automatic logic [3:0] load_size(input logic [3:0] t);
    logic [3:0] n;
    case (t)
      LOAD_BYTE, LOAD_BYTE_UNSIGNED:         n = 4'd1;
      LOAD_HALFWORD, LOAD_HALFWORD_UNSIGNED: n = 4'd2;
      LOAD_WORD:                             n = 4'd4;
      LOAD_DOUBLEWORD:                       n = 4'd8;
      default:                               n = 4'd0;
    endcase
    return n;
  endfunction

  // Byte count of a store; 0 marks an unrecognised code.
  function automatic logic [3:0] store_size(input logic [3:0] t);
    logic [3:0] n;
    case (t)
      STORE_BYTE:       n = 4'd1;
      STORE_HALFWORD:   n = 4'd2;
      STORE_WORD:       n = 4'd4;
      STORE_DOUBLEWORD: n = 4'd8;
      default:          n = 4'd0;
    endcase
    return n;
  endfunction

  // Sign/zero extension of the assembled little-endian load buffer.
  function automatic logic [BIT_WIDTH-1:0] load_extend(input logic [BIT_WIDTH-1:0] v,
                                                       input logic [3:0] t);
    logic [BIT_WIDTH-1:0] r;
    case (t)
      LOAD_BYTE:              r = {{56{v[7]}}, v[7:0]};
      LOAD_HALFWORD:          r = {{48{v[15]}}, v[15:0]};
      LOAD_WORD:              r = {{32{v[31]}}, v[31:0]};
      LOAD_DOUBLEWORD:        r = v;
      LOAD_BYTE_UNSIGNED:     r = {56'd0, v[7:0]};
      LOAD_HALFWORD_UNSIGNED: r = {48'd0, v[15:0]};
      default:                r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_serial_ctrl_if.sv
// CPU <-> data-memory bus.
//   addr     : byte address (only the low ADDR_W bits reach memory)
//   wdata    : store data
//   ctrl     : {storetype[3:0], loadtype[3:0], MemWriteEn, MemReadEn, RegWriteEn}
//   rdata    : extended load result
//   stall    : access in progress, CPU holds its state
//   misalign : one-cycle misaligned-access flag
// master = CPU side, slave = memory controller side.
interface dmem_serial_ctrl_if;
  import dmem_serial_ctrl_pkg::*;

  logic [BIT_WIDTH-1:0] addr;
  logic [BIT_WIDTH-1:0] wdata;
  logic [CTRL_W-1:0]    ctrl;
  logic [BIT_WIDTH-1:0] rdata;
  logic                 stall;
  logic                 misalign;

  modport master (output addr, wdata, ctrl, input rdata, stall, misalign);
  modport slave  (input addr, wdata, ctrl, output rdata, stall, misalign);
endinterface

// File: rtl/dmem_byte_ram.sv
// Byte-wide storage for the serial data memory.
//   clk   : write clock
//   we    : synchronous write enable
//   addr  : shared read/write byte address
//   wdata : byte to write
//   rdata : asynchronous read of mem[addr]
// Contents are not reset.
module dmem_byte_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_serial_ctrl.sv
// Serial data-memory controller: performs each CPU load/store one byte per
// clock (little-endian, address wraps at the top of memory) and stalls the
// CPU until the access completes.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : dmem_serial_ctrl_if.slave (addr, wdata, ctrl in; rdata, stall, misalign out)
// Build option: define DMEM_MISALIGN_TRAP_EN to trap accesses with addr mod N != 0
// (no memory access, misalign pulsed in DONE); otherwise they proceed byte-wise.
module dmem_serial_ctrl
  import dmem_serial_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  dmem_serial_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q;
  logic [BIT_WIDTH-1:0] wdata_q, rbuf_q, rbuf_nxt, rdata_q;
  logic                 write_q;
  logic [3:0]           ltype_q;
  logic [2:0]           size_q;
  logic [2:0]           idx_q;
  logic                 misalign_q;
  logic                 stall;

  logic [3:0]        stype, ltype, req_size;
  logic              mem_we, mem_re, req, req_skip, req_misal, last;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic              ram_we;
  logic              unused_bits;

  assign stype  = bus.ctrl[10:7];
  assign ltype  = bus.ctrl[6:3];
  assign mem_we = bus.ctrl[2];
  assign mem_re = bus.ctrl[1];
  assign req    = mem_we | mem_re;
  assign unused_bits = ^{bus.addr[BIT_WIDTH-1:ADDR_W], bus.ctrl[0]};

  // Write wins when both enables are set.
  assign req_size = mem_we ? store_size(stype) : load_size(ltype);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misal = (req_size != 4'd0) && ((bus.addr[3:0] & (req_size - 4'd1)) != 4'd0);
`else
  assign req_misal = 1'b0;
`endif

  assign req_skip = (req_size == 4'd0) || req_misal;

  // Sizes are 1/2/4/8, so size[2:0]-1 is the last index (8 -> 0-1 = 7).
  assign last = (idx_q == (size_q - 3'd1));

  assign ram_addr  = base_q + ADDR_W'(idx_q);
  assign ram_wdata = wdata_q[{idx_q, 3'b000} +: 8];
  assign ram_we    = (state_q == ACCESS) && write_q;

  dmem_byte_ram #(
    .DEPTH (MEMORY_SIZE),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    rbuf_nxt = rbuf_q;
    rbuf_nxt[{idx_q, 3'b000} +: 8] = ram_rdata;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = req_skip ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      ltype_q    <= '0;
      size_q     <= '0;
      idx_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            base_q  <= bus.addr[ADDR_W-1:0];
            wdata_q <= bus.wdata;
            write_q <= mem_we;
            ltype_q <= ltype;
            size_q  <= req_size[2:0];
            idx_q   <= '0;
            rbuf_q  <= '0;
            if (req_skip) begin
              misalign_q <= req_misal;
              if (!mem_we) rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          idx_q  <= idx_q + 3'd1;
          rbuf_q <= rbuf_nxt;
          // Last byte is merged combinationally so rdata is valid in DONE.
          if (last && !write_q) rdata_q <= load_extend(rbuf_nxt, ltype_q);
        end
        default: ;
      endcase
    end
  end

  // Reset forces stall low even while a request is presented.
  assign bus.stall    = stall & rst;
  assign bus.rdata    = rdata_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_dmem_serial_ctrl.sv
module tb_dmem_serial_ctrl;
  import dmem_serial_ctrl_pkg::*;

  typedef struct {
    string       tag;
    int unsigned stall_cyc;
    logic        mis;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_serial_ctrl_if bus ();

  dmem_serial_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        sb_q[$];
  logic [7:0]  mdl_mem [0:4095];
  logic [63:0] mdl_rdata = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned mdl_size(input logic we, input logic [3:0] st, input logic [3:0] lt);
    if (we) begin
      case (st)
        STORE_BYTE:       return 1;
        STORE_HALFWORD:   return 2;
        STORE_WORD:       return 4;
        STORE_DOUBLEWORD: return 8;
        default:          return 0;
      endcase
    end
    case (lt)
      LOAD_BYTE, LOAD_BYTE_UNSIGNED:         return 1;
      LOAD_HALFWORD, LOAD_HALFWORD_UNSIGNED: return 2;
      LOAD_WORD:                             return 4;
      LOAD_DOUBLEWORD:                       return 8;
      default:                               return 0;
    endcase
  endfunction

  function automatic logic [63:0] mdl_extend(input logic [63:0] v, input logic [3:0] lt);
    case (lt)
      LOAD_BYTE:              return 64'($signed(v[7:0]));
      LOAD_HALFWORD:          return 64'($signed(v[15:0]));
      LOAD_WORD:              return 64'($signed(v[31:0]));
      LOAD_BYTE_UNSIGNED:     return 64'(v[7:0]);
      LOAD_HALFWORD_UNSIGNED: return 64'(v[15:0]);
      default:                return v;
    endcase
  endfunction

  // Entered #1 after a rising edge with the DUT idle; leaves it the same way.
  task automatic do_access(input string tag, input logic [3:0] st, input logic [3:0] lt,
                           input logic we, input logic re,
                           input logic [63:0] a, input logic [63:0] wd);
    exp_t        e;
    int unsigned n;
    int unsigned cyc;
    logic        mis;
    logic        ok;
    logic [63:0] v;
    logic [11:0] ba;
    n   = mdl_size(we, st, lt);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (n != 0 && (int'(a[11:0]) % n) != 0) mis = 1'b1;
`endif
    e.tag = tag;
    e.mis = mis;
    if (n == 0 || mis) begin
      e.stall_cyc = 1;
      if (!we) mdl_rdata = '0;
    end else begin
      e.stall_cyc = n + 1;
      v = '0;
      for (int unsigned k = 0; k < n; k++) begin
        ba = a[11:0] + 12'(k);
        if (we) mdl_mem[ba] = wd[8*k +: 8];
        else    v[8*k +: 8] = mdl_mem[ba];
      end
      if (!we) mdl_rdata = mdl_extend(v, lt);
    end
    e.rdata = mdl_rdata;
    sb_q.push_back(e);

    bus.addr  = a;
    bus.wdata = wd;
    bus.ctrl  = {st, lt, we, re, 1'b1};
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    e = sb_q.pop_front();
    if (!ok) begin
      check_val({e.tag, ".timeout"}, 64'(cyc), 64'(e.stall_cyc));
    end else begin
      check_val({e.tag, ".stall"}, 64'(cyc), 64'(e.stall_cyc));
      check_val({e.tag, ".misalign"}, 64'(bus.misalign), 64'(e.mis));
      check_val({e.tag, ".rdata"}, bus.rdata, e.rdata);
    end
    @(posedge clk);
    #1;
    bus.ctrl = '0;
    @(negedge clk);
    check_val({e.tag, ".idle"}, {62'd0, bus.stall, bus.misalign}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sc [4];
    logic [3:0]  lc [6];
    logic [63:0] a;
    logic [63:0] wd;

    sc = '{STORE_BYTE, STORE_HALFWORD, STORE_WORD, STORE_DOUBLEWORD};
    lc = '{LOAD_BYTE, LOAD_HALFWORD, LOAD_WORD, LOAD_DOUBLEWORD,
           LOAD_BYTE_UNSIGNED, LOAD_HALFWORD_UNSIGNED};
    for (int i = 0; i < 4096; i++) mdl_mem[i] = 8'h00;

    // Reset with a request presented: outputs must stay quiet.
    bus.addr  = 64'h100;
    bus.wdata = '0;
    bus.ctrl  = {4'd0, LOAD_DOUBLEWORD, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    check_val("rst.stall", 64'(bus.stall), 64'd0);
    check_val("rst.misalign", 64'(bus.misalign), 64'd0);
    check_val("rst.rdata", bus.rdata, 64'd0);
    bus.ctrl = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_access("sd100", STORE_DOUBLEWORD, 4'd0, 1'b1, 1'b0, 64'h100, 64'h1122334455667788);
    do_access("ld100", 4'd0, LOAD_DOUBLEWORD, 1'b0, 1'b1, 64'h100, '0);
    do_access("lb107", 4'd0, LOAD_BYTE, 1'b0, 1'b1, 64'h107, '0);
    do_access("sb200", STORE_BYTE, 4'd0, 1'b1, 1'b0, 64'h200, 64'h80);
    do_access("lb200", 4'd0, LOAD_BYTE, 1'b0, 1'b1, 64'h200, '0);
    do_access("lbu200", 4'd0, LOAD_BYTE_UNSIGNED, 1'b0, 1'b1, 64'h200, '0);
    do_access("sh210", STORE_HALFWORD, 4'd0, 1'b1, 1'b0, 64'h210, 64'h8001);
    do_access("lh210", 4'd0, LOAD_HALFWORD, 1'b0, 1'b1, 64'h210, '0);
    do_access("lhu210", 4'd0, LOAD_HALFWORD_UNSIGNED, 1'b0, 1'b1, 64'h210, '0);

    // Wrap-around at the top of memory.
    do_access("sdFFC", STORE_DOUBLEWORD, 4'd0, 1'b1, 1'b0, 64'hFFC, 64'hA1A2A3A4A5A6A7A8);
    do_access("lwFFE", 4'd0, LOAD_WORD, 1'b0, 1'b1, 64'hFFE, '0);
    do_access("ld000", 4'd0, LOAD_DOUBLEWORD, 1'b0, 1'b1, 64'h1000, '0);

    // Misaligned halfword, then read back the surrounding doubleword.
    do_access("sh101", STORE_HALFWORD, 4'd0, 1'b1, 1'b0, 64'h101, 64'hBEEF);
    do_access("ld100b", 4'd0, LOAD_DOUBLEWORD, 1'b0, 1'b1, 64'h100, '0);

    // Both enables: write only.
    do_access("swrw40", STORE_WORD, LOAD_WORD, 1'b1, 1'b1, 64'h40, 64'hDEADBEEF);
    do_access("lw40", 4'd0, LOAD_WORD, 1'b0, 1'b1, 64'h40, '0);

    // Unrecognised codes.
    do_access("badst", 4'hF, 4'd0, 1'b1, 1'b0, 64'h40, 64'h55);
    do_access("badld", 4'd0, 4'hF, 1'b0, 1'b1, 64'h40, '0);
    do_access("lw40b", 4'd0, LOAD_WORD, 1'b0, 1'b1, 64'h40, '0);

    // Reset during byte 2 of a doubleword store.
    do_access("sd300a", STORE_DOUBLEWORD, 4'd0, 1'b1, 1'b0, 64'h300, 64'h0102030405060708);
    bus.addr  = 64'h300;
    bus.wdata = 64'hF1F2F3F4F5F6F7F8;
    bus.ctrl  = {STORE_DOUBLEWORD, 4'd0, 1'b1, 1'b0, 1'b0};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst.stall", 64'(bus.stall), 64'd0);
    check_val("midrst.rdata", bus.rdata, 64'd0);
    check_val("midrst.misalign", 64'(bus.misalign), 64'd0);
    mdl_mem[12'h300] = 8'hF8;
    mdl_mem[12'h301] = 8'hF7;
    mdl_rdata = '0;
    bus.ctrl = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_access("ld300", 4'd0, LOAD_DOUBLEWORD, 1'b0, 1'b1, 64'h300, '0);

    // Random traffic over a pre-written window.
    for (int i = 0; i < 8; i++)
      do_access("pre400", STORE_DOUBLEWORD, 4'd0, 1'b1, 1'b0, 64'h400 + 64'(8*i),
                {$urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      a  = 64'h400 + 64'($urandom_range(0, 'h37));
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_access("rnd.st", sc[$urandom_range(0, 3)], 4'd0, 1'b1, 1'b0, a, wd);
      else
        do_access("rnd.ld", 4'd0, lc[$urandom_range(0, 5)], 1'b0, 1'b1, a, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
